beta_lsu_gen2: RTL and testbench

Second-generation load/store unit for the beta execute stage. It is parametrised in data width, sign-extends or zero-extends sub-word loads, and rejects misaligned accesses. It runs a registered request/ready/valid handshake on separate read and write memory ports, with an optional response watchdog. It sits between the execute control unit, which issues operations and stalls on `lsu_busy_o`, and the data memory ports of the stage.

---
 rtl/beta_lsu_gen2.sv | 176 +++++++++++++++++
 tb/tb_beta_lsu_gen2.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beta_lsu_gen2.sv
// beta_lsu_gen2: load/store unit with registered request/ready/valid memory ports.
// Define BETA_LSU_TIMEOUT_EN to compile in the response watchdog.
module beta_lsu_gen2 #(
    parameter int DataWidth     = 32,
    parameter int AddressWidth  = 32,
    parameter int TimeoutCycles = 255
) (
    input  logic                      clk_i,
    input  logic                      rstn_i,
    input  logic                      lsu_op_en_i,
    input  logic                      lsu_op_i,
    input  logic [1:0]                lsu_op_size_i,
    input  logic                      lsu_unsigned_i,
    input  logic [AddressWidth-1:0]   op_addr_i,
    input  logic [DataWidth-1:0]      op_data_i,
    output logic                      lsu_busy_o,
    output logic                      lsu_done_o,
    output logic [DataWidth-1:0]      lsu_result_o,
    output logic                      lsu_misaligned_o,
    output logic                      lsu_timeout_o,
    input  logic                      rdata_ready_i,
    input  logic                      rdata_valid_i,
    input  logic [DataWidth-1:0]      rdata_data_i,
    output logic [AddressWidth-1:0]   rdata_addr_o,
    output logic [DataWidth/8-1:0]    rdata_strb_o,
    output logic                      rdata_req_o,
    input  logic                      wdata_ready_i,
    input  logic                      wdata_valid_i,
    output logic [DataWidth-1:0]      wdata_data_o,
    output logic [AddressWidth-1:0]   wdata_addr_o,
    output logic [DataWidth/8-1:0]    wdata_strb_o,
    output logic                      wdata_req_o
);

    localparam int StrbW = DataWidth / 8;
    localparam int LaneW = $clog2(StrbW);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    logic [1:0]              state;
    logic                    op_q;
    logic [1:0]              size_q;
    logic                    uns_q;
    logic                    mis_q;
    logic [DataWidth-1:0]    result_q;
    logic [AddressWidth-1:0] addr_q;
    logic [DataWidth-1:0]    data_q;
    logic [LaneW-1:0]        lane_q;
    logic                    accept;
    logic                    mis_in;
    logic                    ready_hit;
    logic                    valid_hit;
    logic                    expired;
    logic [StrbW-1:0]        strb_q;
    logic [AddressWidth-1:0] addr_al;

    function automatic logic is_misaligned(input logic [1:0] size, input logic [LaneW-1:0] lane);
        if (size == 2'd3 && DataWidth == 32) return 1'b1;
        return (32'(lane) & ((32'd1 << size) - 32'd1)) != 32'd0;
    endfunction

    function automatic logic [StrbW-1:0] strobe(input logic [1:0] size, input logic [LaneW-1:0] lane);
        logic [15:0] span;
        span = 16'((32'd1 << (32'd1 << size)) - 32'd1) << lane;
        return span[StrbW-1:0];
    endfunction

    // Move the access to the top bits, then shift back down arithmetically or logically.
    function automatic logic [DataWidth-1:0] load_extend(input logic [DataWidth-1:0] raw,
                                                         input logic [1:0] size, input logic uns);
        int sh;
        logic signed [DataWidth-1:0] left;
        sh = DataWidth - (8 << size);
        if (sh < 0) sh = 0;
        left = signed'(raw << sh);
        if (uns) return $unsigned(left) >> sh;
        return $unsigned(left >>> sh);
    endfunction

    assign accept    = lsu_op_en_i && (state == IDLE || state == DONE);
    assign mis_in    = is_misaligned(lsu_op_size_i, op_addr_i[LaneW-1:0]);
    assign ready_hit = op_q ? wdata_ready_i : rdata_ready_i;
    assign valid_hit = op_q ? wdata_valid_i : rdata_valid_i;
    assign lane_q    = addr_q[LaneW-1:0];
    assign strb_q    = strobe(size_q, lane_q);
    assign addr_al   = {addr_q[AddressWidth-1:LaneW], {LaneW{1'b0}}};

`ifdef BETA_LSU_TIMEOUT_EN
    localparam int CntW = $clog2(TimeoutCycles + 1);
    logic [CntW-1:0] cnt_q;
    logic            to_q;

    assign expired = (state == REQ || state == WAIT) && (cnt_q == CntW'(TimeoutCycles - 1));

    // Counter restarts on every accept so each REQ entry begins from zero.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cnt_q <= '0;
            to_q  <= 1'b0;
        end else begin
            to_q <= expired;
            if (accept) cnt_q <= '0;
            else if (state == REQ || state == WAIT) cnt_q <= cnt_q + 1'b1;
        end
    end

    assign lsu_timeout_o = lsu_done_o && to_q;
`else
    assign expired       = 1'b0;
    assign lsu_timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= IDLE;
            op_q     <= 1'b0;
            size_q   <= 2'd0;
            uns_q    <= 1'b0;
            mis_q    <= 1'b0;
            result_q <= '0;
        end else begin
            mis_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    if (lsu_op_en_i) begin
                        op_q   <= lsu_op_i;
                        size_q <= lsu_op_size_i;
                        uns_q  <= lsu_unsigned_i;
                        mis_q  <= mis_in;
                        state  <= mis_in ? DONE : REQ;
                    end else begin
                        state <= IDLE;
                    end
                end
                REQ: begin
                    if (expired) state <= DONE;
                    else if (ready_hit) state <= WAIT;
                end
                WAIT: begin
                    if (expired) begin
                        state <= DONE;
                    end else if (valid_hit) begin
                        state <= DONE;
                        if (!op_q) result_q <= load_extend(rdata_data_i >> {lane_q, 3'b000}, size_q, uns_q);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (accept) begin
            addr_q <= op_addr_i;
            data_q <= op_data_i;
        end
    end

    // Request-side outputs are gated so they read as zero outside REQ.
    assign rdata_req_o      = (state == REQ) && !op_q;
    assign wdata_req_o      = (state == REQ) && op_q;
    assign rdata_addr_o     = rdata_req_o ? addr_al : '0;
    assign rdata_strb_o     = rdata_req_o ? strb_q : '0;
    assign wdata_addr_o     = wdata_req_o ? addr_al : '0;
    assign wdata_strb_o     = wdata_req_o ? strb_q : '0;
    assign wdata_data_o     = wdata_req_o ? (data_q << {lane_q, 3'b000}) : '0;

    assign lsu_done_o       = (state == DONE);
    assign lsu_misaligned_o = lsu_done_o && mis_q;
    assign lsu_result_o     = result_q;
    assign lsu_busy_o       = (state == REQ) || (state == WAIT) || accept;

endmodule

// File: tb/tb_beta_lsu_gen2.sv
// Directed bench for beta_lsu_gen2 with a transaction-queue reference model.
module tb_beta_lsu_gen2;

    logic        clk = 1'b0;
    logic        rstn;
    logic        en, op, uns;
    logic [1:0]  size;
    logic [31:0] addr, data;
    logic        busy, done, mis_o, to_o;
    logic [31:0] result;
    logic        rready, rvalid, rreq, wready, wvalid, wreq;
    logic [31:0] rdata, raddr, waddr, wdata;
    logic [3:0]  rstrb, wstrb;

    always #5 clk = ~clk;

    beta_lsu_gen2 #(.DataWidth(32), .AddressWidth(32), .TimeoutCycles(8)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .lsu_op_en_i(en), .lsu_op_i(op), .lsu_op_size_i(size), .lsu_unsigned_i(uns),
        .op_addr_i(addr), .op_data_i(data),
        .lsu_busy_o(busy), .lsu_done_o(done), .lsu_result_o(result),
        .lsu_misaligned_o(mis_o), .lsu_timeout_o(to_o),
        .rdata_ready_i(rready), .rdata_valid_i(rvalid), .rdata_data_i(rdata),
        .rdata_addr_o(raddr), .rdata_strb_o(rstrb), .rdata_req_o(rreq),
        .wdata_ready_i(wready), .wdata_valid_i(wvalid), .wdata_data_o(wdata),
        .wdata_addr_o(waddr), .wdata_strb_o(wstrb), .wdata_req_o(wreq)
    );

    typedef struct packed {
        logic        st;
        logic        mis;
        logic        to;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] wdata;
        logic [31:0] res;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_done = 0;
    logic [31:0] model_result = 32'd0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, req);
    endtask

    function automatic logic m_mis(input logic [1:0] sz, input logic [31:0] a);
        return (sz == 2'd3) || (((a % 4) % (32'd1 << sz)) != 0);
    endfunction

    function automatic logic [3:0] m_strb(input logic [1:0] sz, input logic [31:0] a);
        logic [31:0] t;
        t = ((32'd1 << (32'd1 << sz)) - 32'd1) << (a % 4);
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [31:0] a);
        return d << (8 * (a % 4));
    endfunction

    function automatic logic [31:0] m_res(input logic [31:0] rd, input logic [1:0] sz, input logic u,
                                          input logic [31:0] a);
        longint v;
        int nb;
        nb = 8 << sz;
        v = longint'(rd >> (8 * (a % 4)));
        v = v % (longint'(1) << nb);
        if (!u && v >= (longint'(1) << (nb - 1))) v = v - (longint'(1) << nb);
        return 32'(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic st, input logic [1:0] sz, input logic u, input logic [31:0] a,
                         input logic [31:0] d, input logic [31:0] rd, input logic to);
        exp_t e;
        e.st = st; e.mis = m_mis(sz, a); e.to = to;
        e.addr = a & ~32'h3; e.strb = m_strb(sz, a);
        e.wdata = m_wdata(d, a); e.res = m_res(rd, sz, u, a);
        q.push_back(e);
        en = 1'b1; op = st; size = sz; uns = u; addr = a; data = d;
    endtask

    task automatic run_op(input logic st, input logic [1:0] sz, input logic u, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] rd, input int rdly, input int vdly,
                          input logic early_v);
        issue(st, sz, u, a, d, rd, 1'b0);
        @(negedge clk);
        chk("busy_issue", busy, 1);
        step();
        en = 1'b0;
        if (m_mis(sz, a)) begin
            @(negedge clk);
            chk("mis_done", done, 1);
            chk("mis_noreq", rreq | wreq, 0);
            return;
        end
        for (int k = 0; k <= rdly; k++) begin
            if (st) wready = (k == rdly); else rready = (k == rdly);
            if (early_v && k == rdly) begin
                if (st) wvalid = 1'b1; else rvalid = 1'b1;
            end
            @(negedge clk);
            chk("req_asserted", st ? wreq : rreq, 1);
            chk("busy_req", busy, 1);
            chk("no_done_req", done, 0);
            step();
        end
        rready = 1'b0; wready = 1'b0; rvalid = 1'b0; wvalid = 1'b0;
        for (int k = 0; k <= vdly; k++) begin
            if (k == vdly) begin
                if (st) wvalid = 1'b1;
                else begin rvalid = 1'b1; rdata = rd; end
            end
            @(negedge clk);
            chk("req_dropped", rreq | wreq, 0);
            chk("busy_wait", busy, 1);
            chk("no_done_wait", done, 0);
            step();
        end
        rvalid = 1'b0; wvalid = 1'b0; rdata = 32'd0;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("busy_done", busy, 0);
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            q.delete();
            model_result = 32'd0;
            chk("reset_outputs", |{busy, done, result, mis_o, to_o, rreq, raddr, rstrb,
                                   wreq, waddr, wstrb, wdata}, 0);
        end else begin
            if (done) begin
                n_done++;
                if (q.size() == 0) chk("spurious_done", 1, 0);
                else begin
                    cur = q.pop_front();
                    chk("done_misaligned", mis_o, cur.mis);
                    chk("done_timeout", to_o, cur.to);
                    if (!cur.st && !cur.mis && !cur.to) model_result = cur.res;
                end
            end else begin
                chk("flags_idle", {mis_o, to_o}, 0);
            end
            chk("result_held", result, model_result);
            chk("req_exclusive", rreq & wreq, 0);
            if (rreq) begin
                if (q.size() == 0) chk("spurious_rreq", 1, 0);
                else begin
                    chk("rreq_kind", q[0].st, 0);
                    chk("rdata_addr", raddr, q[0].addr);
                    chk("rdata_strb", rstrb, q[0].strb);
                end
            end
            if (wreq) begin
                if (q.size() == 0) chk("spurious_wreq", 1, 0);
                else begin
                    chk("wreq_kind", q[0].st, 1);
                    chk("wdata_addr", waddr, q[0].addr);
                    chk("wdata_strb", wstrb, q[0].strb);
                    chk("wdata_data", wdata, q[0].wdata);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        int exp_done;
        exp_done = 7;
        rstn = 1'b0; en = 1'b0; op = 1'b0; uns = 1'b0; size = 2'd0; addr = 32'd0; data = 32'd0;
        rready = 1'b0; rvalid = 1'b0; wready = 1'b0; wvalid = 1'b0; rdata = 32'd0;
        @(negedge clk);
        step();
        step();
        rstn = 1'b1;

        chk("pin_strb_byte3", m_strb(2'd0, 32'h1003), 4'b1000);
        chk("pin_res_sbyte", m_res(32'h80AABBCC, 2'd0, 1'b0, 32'h1003), 32'hFFFFFF80);
        chk("pin_strb_half2", m_strb(2'd1, 32'h2002), 4'b1100);
        chk("pin_res_uhalf", m_res(32'hBEEF1234, 2'd1, 1'b1, 32'h2002), 32'h0000BEEF);
        chk("pin_wdata_byte1", m_wdata(32'h000000A5, 32'h3001), 32'h0000A500);
        chk("pin_strb_byte1", m_strb(2'd0, 32'h3001), 4'b0010);
        chk("pin_mis_word2", m_mis(2'd2, 32'h4002), 1);

        run_op(1'b0, 2'd0, 1'b0, 32'h1003, 32'd0, 32'h80AABBCC, 0, 0, 1'b0);
        chk("sbyte_result", result, 32'hFFFFFF80);
        step();
        run_op(1'b0, 2'd1, 1'b1, 32'h2002, 32'd0, 32'hBEEF1234, 0, 1, 1'b1);
        chk("uhalf_result", result, 32'h0000BEEF);
        step();
        run_op(1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'd0, 4, 0, 1'b0);
        chk("store_keeps_result", result, 32'h0000BEEF);
        step();
        run_op(1'b0, 2'd2, 1'b0, 32'h4002, 32'd0, 32'd0, 0, 0, 1'b0);
        chk("mis_flag_literal", mis_o, 1);
        chk("mis_keeps_result", result, 32'h0000BEEF);
        step();

        // Second op issued in the DONE cycle of a misaligned one.
        issue(1'b0, 2'd2, 1'b0, 32'h4006, 32'd0, 32'd0, 1'b0);
        @(negedge clk);
        chk("b2b_busy_issue", busy, 1);
        step();
        run_op(1'b0, 2'd2, 1'b0, 32'h5004, 32'd0, 32'h11223344, 0, 0, 1'b0);
        chk("b2b_result", result, 32'h11223344);
        step();

        issue(1'b0, 2'd2, 1'b0, 32'h6000, 32'd0, 32'hCAFEF00D, 1'b0);
        step();
        en = 1'b0;
        rready = 1'b1;
        @(negedge clk);
        chk("rst_case_req", rreq, 1);
        step();
        rready = 1'b0;
        @(negedge clk);
        chk("rst_case_wait_busy", busy, 1);
        #2 rstn = 1'b0;
        #1;
        chk("rst_async_busy", busy, 0);
        chk("rst_async_req", rreq | wreq, 0);
        step();
        @(negedge clk);
        step();
        rstn = 1'b1;
        rvalid = 1'b1;
        rdata = 32'hDEADBEEF;
        @(negedge clk);
        chk("stale_valid_no_done", done, 0);
        step();
        rvalid = 1'b0;
        rdata = 32'd0;
        @(negedge clk);
        chk("stale_valid_idle", busy | done, 0);
        step();
        run_op(1'b0, 2'd2, 1'b1, 32'h6008, 32'd0, 32'h0BADCAFE, 1, 2, 1'b0);
        chk("post_reset_result", result, 32'h0BADCAFE);
        step();

`ifdef BETA_LSU_TIMEOUT_EN
        exp_done = 8;
        issue(1'b0, 2'd2, 1'b0, 32'h7000, 32'd0, 32'd0, 1'b1);
        @(negedge clk);
        chk("to_busy_issue", busy, 1);
        step();
        en = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            chk("to_req_held", rreq, 1);
            chk("to_no_done", done, 0);
            step();
        end
        @(negedge clk);
        chk("to_done", done, 1);
        chk("to_flag", to_o, 1);
        chk("to_req_dropped", rreq, 0);
        chk("to_busy", busy, 0);
        chk("to_result_kept", result, 32'h0BADCAFE);
        step();
`endif

        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", n_done, exp_done);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
